// File: rtl/serial_pattern_detect.sv
// Serial pattern detector.
// Qualified serial bits shift into a W-bit window that is compared against a
// loadable pattern under a loadable care-mask. Matches are reported as a
// registered one-cycle pulse and tallied in a saturating counter.
module serial_pattern_detect #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic [W-1:0]     pattern,
  input  logic [W-1:0]     mask,
  input  logic             p_load,
  input  logic             overlap,
  input  logic             o_load,
  input  logic             count_clr,
  output logic             found,
  output logic [CNT_W-1:0] match_count
);

  localparam int FILL_W = $clog2(W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  // Counter increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Fill count after one more sample, clamped at a full window.
  function automatic logic [FILL_W-1:0] fillSat(input logic [FILL_W-1:0] v);
    return (v == FILL_FULL) ? FILL_FULL : v + FILL_W'(1);
  endfunction

  logic [W-1:0]      patQ;
  logic [W-1:0]      mskQ;
  logic              ovlQ;
  logic [W-1:0]      srQ;
  logic [FILL_W-1:0] fillQ;

  logic [W-1:0]      srNext;
  logic [FILL_W-1:0] fillSample;
  logic [FILL_W-1:0] fillNext;
  logic [W-1:0]      maskedDiff;
  logic              windowFull;
  logic              isMatch;
  logic              anyLoad;

  // Window shift, fill tracking and match decision for the coming edge.
  always_comb begin
    srNext     = srQ;
    fillSample = fillQ;
    fillNext   = fillQ;
    maskedDiff = '0;
    windowFull = 1'b0;
    isMatch    = 1'b0;
    anyLoad    = p_load | o_load;

    if (ser_valid) begin
      // Newest bit enters at the MSB so bit 0 holds the oldest sample.
      srNext     = {ser_in, srQ[W-1:1]};
      fillSample = fillSat(fillQ);
    end

    // Old pattern/mask/mode govern this edge; a load suppresses any match
    // because the freshly loaded settings restart the window count.
    maskedDiff = (srNext ^ patQ) & mskQ;
    windowFull = (fillSample == FILL_FULL);
    isMatch    = ser_valid && !anyLoad && windowFull && (maskedDiff == '0);

    if (anyLoad) begin
      fillNext = '0;
    end else if (isMatch && !ovlQ) begin
      // Non-overlapping search: the next match needs W fresh samples.
      fillNext = '0;
    end else begin
      fillNext = fillSample;
    end
  end

  // Pattern and care-mask registers, loaded together.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      patQ <= '0;
      mskQ <= '1;
    end else if (p_load) begin
      patQ <= pattern;
      mskQ <= mask;
    end
  end

  // Search-mode register.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      ovlQ <= 1'b0;
    end else if (o_load) begin
      ovlQ <= overlap;
    end
  end

  // Sample window and fill counter; reset discards any partial window.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      srQ   <= '0;
      fillQ <= '0;
    end else begin
      srQ   <= srNext;
      fillQ <= fillNext;
    end
  end

  // Registered one-cycle match pulse.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      found <= 1'b0;
    end else begin
      found <= isMatch;
    end
  end

  // Saturating match counter; clear wins over a same-edge increment.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      match_count <= '0;
    end else if (count_clr) begin
      match_count <= '0;
    end else if (isMatch) begin
      match_count <= satInc(match_count);
    end
  end

endmodule

// File: tb/tb_serial_pattern_detect.sv
// Directed bench for serial_pattern_detect with W=4, CNT_W=3.
module tb_serial_pattern_detect;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       ser_in;
  logic       ser_valid;
  logic [3:0] pattern;
  logic [3:0] mask;
  logic       p_load;
  logic       overlap;
  logic       o_load;
  logic       count_clr;
  logic       found;
  logic [2:0] match_count;

  int checks = 0;
  int errors = 0;

  serial_pattern_detect #(.W(4), .CNT_W(3)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .ser_in      (ser_in),
    .ser_valid   (ser_valid),
    .pattern     (pattern),
    .mask        (mask),
    .p_load      (p_load),
    .overlap     (overlap),
    .o_load      (o_load),
    .count_clr   (count_clr),
    .found       (found),
    .match_count (match_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rstN;
    logic       sv;
    logic       si;
    logic       pl;
    logic       ol;
    logic       ovl;
    logic       clr;
    logic [3:0] pat;
    logic [3:0] msk;
    logic       expF;
    logic [2:0] expC;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rstN, input logic sv, input logic si,
                     input logic pl, input logic ol, input logic ovl,
                     input logic clr, input logic [3:0] pat,
                     input logic [3:0] msk, input logic expF,
                     input logic [2:0] expC);
    vec_t v;
    v.rstN = rstN; v.sv = sv; v.si = si; v.pl = pl; v.ol = ol; v.ovl = ovl;
    v.clr = clr; v.pat = pat; v.msk = msk; v.expF = expF; v.expC = expC;
    vecs.push_back(v);
  endtask

  // Plain sample / idle helpers (no loads, no clear, reset released).
  task automatic addS(input logic si, input logic expF, input logic [2:0] expC);
    add(1, 1, si, 0, 0, 0, 0, 4'b0000, 4'b0000, expF, expC);
  endtask

  task automatic addI(input logic expF, input logic [2:0] expC);
    add(1, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, expF, expC);
  endtask

  task automatic check(input string nm, input int idx, input logic expF,
                       input logic [2:0] expC);
    checks++;
    if (found !== expF) begin
      errors++;
      $display("FAIL %s[%0d] found: got %0b want %0b", nm, idx, found, expF);
    end
    checks++;
    if (match_count !== expC) begin
      errors++;
      $display("FAIL %s[%0d] match_count: got %0d want %0d", nm, idx, match_count, expC);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n     = v.rstN;
    ser_valid = v.sv;
    ser_in    = v.si;
    p_load    = v.pl;
    o_load    = v.ol;
    overlap   = v.ovl;
    count_clr = v.clr;
    pattern   = v.pat;
    mask      = v.msk;
  endtask

  // One clock with the given inputs, then compare after the edge settles.
  task automatic step(input string nm, input int idx, input vec_t v);
    drive(v);
    @(posedge clock);
    #1;
    check(nm, idx, v.expF, v.expC);
  endtask

  initial begin
    vec_t v;
    rst_n = 0; ser_in = 0; ser_valid = 0; pattern = '0; mask = '0;
    p_load = 0; overlap = 0; o_load = 0; count_clr = 0;

    // Reset with toggling samples, then prove mask resets to all ones:
    // with pattern 0 the window 1,0,0,0 must not match, 0,0,0,0 must.
    add(0, 1, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    addS(1, 0, 0); addS(0, 0, 0); addS(0, 0, 0); addS(0, 0, 0);
    addS(0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 0, 0);

    // Overlap: pattern 1011 (stream 1,1,0,1), both loads in one cycle.
    add(1, 0, 0, 1, 1, 1, 0, 4'b1011, 4'b1111, 0, 0);
    addS(1, 0, 0); addS(1, 0, 0); addS(0, 0, 0); addS(1, 1, 1);
    addS(1, 0, 1); addS(0, 0, 1); addS(1, 1, 2);
    addI(0, 2);

    // Non-overlap on the same stream; clear count alongside the mode load.
    add(1, 0, 0, 0, 1, 0, 1, 4'b0000, 4'b0000, 0, 0);
    addS(1, 0, 0); addS(1, 0, 0); addS(0, 0, 0); addS(1, 1, 1);
    addS(1, 0, 1); addS(0, 0, 1); addS(1, 0, 1);

    // Mask and gaps: only bits 1,2 compared, idle cycles interleaved.
    add(1, 0, 0, 1, 0, 0, 1, 4'b0110, 4'b0110, 0, 0);
    addS(1, 0, 0); addI(0, 0); addS(1, 0, 0); addI(0, 0);
    addS(1, 0, 0); addI(0, 0); addS(1, 1, 1); addI(0, 1);

    // Load mid-window: the completing sample coincides with p_load.
    add(1, 0, 0, 1, 0, 0, 1, 4'b1011, 4'b1111, 0, 0);
    addS(1, 0, 0); addS(1, 0, 0); addS(0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0, 4'b1011, 4'b1111, 0, 0);
    addS(1, 0, 0); addS(1, 0, 0); addS(0, 0, 0); addS(1, 1, 1);

    foreach (vecs[i]) step("table", i, vecs[i]);

    // Counter saturation: overlap, pattern 1111, twelve ones.
    v = '{rstN:1, sv:0, si:0, pl:1, ol:1, ovl:1, clr:1,
          pat:4'b1111, msk:4'b1111, expF:0, expC:0};
    step("satload", 0, v);
    for (int k = 1; k <= 12; k++) begin
      v = '{rstN:1, sv:1, si:1, pl:0, ol:0, ovl:0, clr:0,
            pat:4'b0000, msk:4'b0000, expF:(k >= 4),
            expC:((k < 4) ? 3'd0 : ((k - 3 > 7) ? 3'd7 : 3'(k - 3)))};
      step("sat", k, v);
    end
    // Clear together with a match: pulse still fires, count forced to 0.
    v = '{rstN:1, sv:1, si:1, pl:0, ol:0, ovl:0, clr:1,
          pat:4'b0000, msk:4'b0000, expF:1, expC:0};
    step("clrwin", 0, v);
    v.clr = 0; v.expC = 1;
    step("afterclr", 0, v);

    // All-zero mask in overlap mode: every full-window sample matches.
    v = '{rstN:1, sv:0, si:0, pl:1, ol:0, ovl:0, clr:1,
          pat:4'b1010, msk:4'b0000, expF:0, expC:0};
    step("mask0load", 0, v);
    for (int k = 1; k <= 5; k++) begin
      v = '{rstN:1, sv:1, si:k[0], pl:0, ol:0, ovl:0, clr:0,
            pat:4'b0000, msk:4'b0000, expF:(k >= 4),
            expC:((k < 4) ? 3'd0 : 3'(k - 3))};
      step("mask0", k, v);
    end

    // Reset mid-stream clears pulse and count even with a sample present.
    v = '{rstN:0, sv:1, si:1, pl:0, ol:0, ovl:0, clr:0,
          pat:4'b0000, msk:4'b0000, expF:0, expC:0};
    step("midrst", 0, v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
